// File: rtl/time_set_pkg.sv
// Shared types and limits for the HH:MM:SS time-setting controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;
  localparam int HOUR_W     = 7;
  localparam int MINSEC_W   = 6;

  function automatic logic is_set_state(input state_t s);
    return (s == ST_SET_HR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
  endfunction

  // Display digits HEX5..HEX0 are HH MM SS, two digits per field.
  function automatic logic [5:0] field_mask(input state_t s);
    case (s)
      ST_SET_HR:  return 6'b110000;
      ST_SET_MIN: return 6'b001100;
      ST_SET_SEC: return 6'b000011;
      default:    return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/wrap_updown.sv
// Shadow register for one time field: clamped capture plus wrapping inc/dec.
module wrap_updown #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  input  logic         en,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  // inc and dec together cancel; load wins over everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= (load_val > MAX_V) ? '0 : load_val;
    end else if (en && inc && !dec) begin
      value <= (value == MAX_V) ? '0 : value + W'(1);
    end else if (en && dec && !inc) begin
      value <= (value == '0) ? MAX_V : value - W'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven set mode for the HH:MM:SS timer: freeze, edit HR/MIN/SEC, commit.
// Handshake: the three button inputs are single-cycle pulses with no back-pressure; o_load is a one-cycle strobe.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 32'd50_000_000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter int unsigned TIMEOUT_S  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_mode_pulse,
  input  logic                i_inc_pulse,
  input  logic                i_dec_pulse,
  input  logic [MINSEC_W-1:0] i_seconds,
  input  logic [MINSEC_W-1:0] i_minutes,
  input  logic [HOUR_W-1:0]   i_hours,
  output logic                o_run_en,
  output logic                o_load,
  output logic [MINSEC_W-1:0] o_set_seconds,
  output logic [MINSEC_W-1:0] o_set_minutes,
  output logic [HOUR_W-1:0]   o_set_hours,
  output logic                o_editing,
  output logic [5:0]          o_blank_mask
);

  localparam logic [31:0] PRE_MAX  = 32'(CLOCK_FREQ / (2 * BLINK_HZ) - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_S * 2 * BLINK_HZ - 1);

  state_t      state, state_n;
  logic [31:0] pre, pre_n;
  logic [31:0] tmo, tmo_n;
  logic        phase, phase_n;
  logic        toggle, any_btn, capture;
  logic        en_hr, en_min, en_sec;

  assign any_btn = i_mode_pulse | i_inc_pulse | i_dec_pulse;
  assign capture = (state == ST_RUN) && i_mode_pulse;
  assign en_hr   = (state == ST_SET_HR)  && !i_mode_pulse;
  assign en_min  = (state == ST_SET_MIN) && !i_mode_pulse;
  assign en_sec  = (state == ST_SET_SEC) && !i_mode_pulse;

  always_comb begin
    state_n = state;
    pre_n   = pre;
    phase_n = phase;
    tmo_n   = tmo;
    toggle  = 1'b0;

    case (state)
      ST_RUN:     if (i_mode_pulse) state_n = ST_SET_HR;
      ST_SET_HR:  if (i_mode_pulse) state_n = ST_SET_MIN;
      ST_SET_MIN: if (i_mode_pulse) state_n = ST_SET_SEC;
      ST_SET_SEC: if (i_mode_pulse) state_n = ST_COMMIT;
      default:    state_n = ST_RUN;
    endcase

    if (is_set_state(state)) begin
      if (pre == PRE_MAX) begin
        pre_n   = '0;
        phase_n = ~phase;
        toggle  = 1'b1;
      end else begin
        pre_n = pre + 32'd1;
      end
      if (any_btn) begin
        tmo_n = '0;
      end else if (toggle) begin
        tmo_n = tmo + 32'd1;
        // Abandon the edit; shadows are discarded because no load is issued.
        if (tmo == TMO_LAST) state_n = ST_RUN;
      end
    end

    // Each newly entered field starts in the visible half of the blink.
    if (state_n != state || !is_set_state(state_n)) begin
      pre_n   = '0;
      phase_n = 1'b0;
    end
    if (!is_set_state(state_n) || (state_n == ST_SET_HR && state != ST_SET_HR)) begin
      tmo_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      pre          <= '0;
      phase        <= 1'b0;
      tmo          <= '0;
      o_run_en     <= 1'b1;
      o_load       <= 1'b0;
      o_editing    <= 1'b0;
      o_blank_mask <= '0;
    end else begin
      state        <= state_n;
      pre          <= pre_n;
      phase        <= phase_n;
      tmo          <= tmo_n;
      o_run_en     <= (state_n == ST_RUN);
      o_load       <= (state_n == ST_COMMIT);
      o_editing    <= is_set_state(state_n);
      o_blank_mask <= phase_n ? field_mask(state_n) : 6'b000000;
    end
  end

  wrap_updown #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hours (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_val (i_hours),
    .inc      (i_inc_pulse),
    .dec      (i_dec_pulse),
    .en       (en_hr),
    .value    (o_set_hours)
  );

  wrap_updown #(.W(MINSEC_W), .MAX(MINSEC_MAX)) u_minutes (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_val (i_minutes),
    .inc      (i_inc_pulse),
    .dec      (i_dec_pulse),
    .en       (en_min),
    .value    (o_set_minutes)
  );

  wrap_updown #(.W(MINSEC_W), .MAX(MINSEC_MAX)) u_seconds (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_val (i_seconds),
    .inc      (i_inc_pulse),
    .dec      (i_dec_pulse),
    .en       (en_sec),
    .value    (o_set_seconds)
  );

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with an 8 Hz clock, 1 Hz blink and 2 s timeout.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_p = 1'b0, inc_p = 1'b0, dec_p = 1'b0;
  logic [5:0] live_sec = '0, live_min = '0;
  logic [6:0] live_hr = '0;
  logic       run_en, load, editing;
  logic [5:0] set_sec, set_min, blank_mask;
  logic [6:0] set_hr;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int load_cnt = 0;

  time_set_ctrl #(.CLOCK_FREQ(32'd8), .BLINK_HZ(1), .TIMEOUT_S(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mode_pulse  (mode_p),
    .i_inc_pulse   (inc_p),
    .i_dec_pulse   (dec_p),
    .i_seconds     (live_sec),
    .i_minutes     (live_min),
    .i_hours       (live_hr),
    .o_run_en      (run_en),
    .o_load        (load),
    .o_set_seconds (set_sec),
    .o_set_minutes (set_min),
    .o_set_hours   (set_hr),
    .o_editing     (editing),
    .o_blank_mask  (blank_mask)
  );

  // Clock and load-strobe monitor
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load === 1'b1) load_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse sampled by exactly one rising edge; returns on the following falling edge.
  task automatic pulse(input logic m, input logic i, input logic d);
    @(negedge clk);
    mode_p = m;
    inc_p  = i;
    dec_p  = d;
    @(negedge clk);
    mode_p = 1'b0;
    inc_p  = 1'b0;
    dec_p  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_live(input logic [6:0] h, input logic [5:0] m, input logic [5:0] s);
    live_hr  = h;
    live_min = m;
    live_sec = s;
  endtask

  initial begin
    // Reset state
    idle(2);
    rst = 1'b0;
    check("rst_run_en", 32'(run_en), 32'd1);
    check("rst_load", 32'(load), 32'd0);
    check("rst_editing", 32'(editing), 32'd0);
    check("rst_set_time", {13'd0, set_hr, set_min, set_sec}, 32'd0);
    check("rst_mask", 32'(blank_mask), 32'd0);

    // Basic edit 12:34:56 -> 15:33:57
    set_live(7'd12, 6'd34, 6'd56);
    pulse(1'b0, 1'b1, 1'b0);
    check("run_ignores_inc", {30'd0, editing, run_en}, 32'b01);
    pulse(1'b1, 1'b0, 1'b0);
    check("enter_run_en", 32'(run_en), 32'd0);
    check("enter_editing", 32'(editing), 32'd1);
    check("capture", {13'd0, set_hr, set_min, set_sec}, {13'd0, 7'd12, 6'd34, 6'd56});
    check("enter_mask", 32'(blank_mask), 32'd0);
    repeat (3) pulse(1'b0, 1'b1, 1'b0);
    check("hr_inc3", 32'(set_hr), 32'd15);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check("min_dec", 32'(set_min), 32'd33);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("sec_inc", 32'(set_sec), 32'd57);
    pulse(1'b1, 1'b0, 1'b0);
    check("commit_load", 32'(load), 32'd1);
    check("commit_run_en", 32'(run_en), 32'd0);
    check("commit_value", {13'd0, set_hr, set_min, set_sec}, {13'd0, 7'd15, 6'd33, 6'd57});
    idle(1);
    check("post_commit_load", 32'(load), 32'd0);
    check("post_commit_run", {30'd0, editing, run_en}, 32'b01);

    // Wrap, priority and blink
    set_live(7'd23, 6'd0, 6'd59);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("hr_wrap_up", 32'(set_hr), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("hr_wrap_down", 32'(set_hr), 32'd23);
    pulse(1'b1, 1'b1, 1'b0);
    check("mode_beats_inc", 32'(set_hr), 32'd23);
    check("min_blink_0", 32'(blank_mask), 32'd0);
    idle(3);
    check("min_blink_3", 32'(blank_mask), 32'd0);
    idle(1);
    check("min_blink_on", 32'(blank_mask), 32'b001100);
    idle(4);
    check("min_blink_off", 32'(blank_mask), 32'd0);
    pulse(1'b0, 1'b0, 1'b1);
    check("min_wrap_down", {13'd0, set_hr, set_min, set_sec}, {13'd0, 7'd23, 6'd59, 6'd59});
    pulse(1'b0, 1'b1, 1'b1);
    check("inc_dec_cancel", 32'(set_min), 32'd59);
    pulse(1'b1, 1'b0, 1'b0);
    check("sec_blink_0", 32'(blank_mask), 32'd0);
    idle(3);
    check("sec_blink_3", 32'(blank_mask), 32'd0);
    idle(1);
    check("sec_blink_on", 32'(blank_mask), 32'b000011);
    idle(3);
    check("sec_blink_hold", 32'(blank_mask), 32'b000011);
    idle(1);
    check("sec_blink_off", 32'(blank_mask), 32'd0);
    pulse(1'b0, 1'b1, 1'b0);
    check("sec_wrap_up", 32'(set_sec), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check("commit2_load", 32'(load), 32'd1);
    check("commit2_value", {13'd0, set_hr, set_min, set_sec}, {13'd0, 7'd23, 6'd59, 6'd0});
    idle(1);

    // Timeout abandons the edit without a load
    set_live(7'd5, 6'd6, 6'd7);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("tmo_hr_inc", 32'(set_hr), 32'd6);
    idle(2);
    check("hr_blink_on", 32'(blank_mask), 32'b110000);
    idle(7);
    check("tmo_still_editing", {30'd0, editing, run_en}, 32'b10);
    idle(6);
    check("tmo_back_to_run", {30'd0, editing, run_en}, 32'b01);
    check("tmo_mask", 32'(blank_mask), 32'd0);
    check("tmo_shadow_held", 32'(set_hr), 32'd6);
    check("tmo_no_load", 32'(load_cnt), 32'd2);

    // Clamped capture, then asynchronous reset mid-edit
    set_live(7'd30, 6'd45, 6'd63);
    pulse(1'b1, 1'b0, 1'b0);
    check("clamp_capture", {13'd0, set_hr, set_min, set_sec}, {13'd0, 7'd0, 6'd45, 6'd0});
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("clamp_sec_inc", 32'(set_sec), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_flags", {29'd0, run_en, editing, load}, 32'b100);
    check("arst_set_time", {13'd0, set_hr, set_min, set_sec}, 32'd0);
    check("arst_mask", 32'(blank_mask), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);
    check("post_rst_run", {30'd0, editing, run_en}, 32'b01);
    check("post_rst_sec", 32'(set_sec), 32'd0);
    check("total_loads", 32'(load_cnt), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
